riscv_regfile_mp: RTL and testbench



---
 rtl/riscv_regfile_mp_pkg.sv | 12 +
 rtl/riscv_regfile_wrsel.sv | 29 ++
 rtl/riscv_regfile_mp.sv | 133 +++++++++++++
 tb/tb_riscv_regfile_mp.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_regfile_mp_pkg.sv
// Shared configuration for the multi-port register file: default data width and register counts.
// The optional write-to-read bypass is enabled by defining RISCV_REGFILE_BYPASS_EN (undefined by default).
`ifndef XLEN
`define XLEN 32
`endif

package riscv_regfile_mp_pkg;
    localparam int RV32I_NREG = 32;
    localparam int RV32E_NREG = 16;
    localparam int RV32I_AW   = $clog2(RV32I_NREG);
    localparam int RV32E_AW   = $clog2(RV32E_NREG);
endpackage

// File: rtl/riscv_regfile_wrsel.sv
// Resolves the write enable and write data for one register address across all write ports.
// Higher port index wins. Address 0 never matches.
module riscv_regfile_wrsel
    import riscv_regfile_mp_pkg::*;
#(
    parameter int XLEN = `XLEN,
    parameter int AW   = RV32I_AW,
    parameter int NWR  = 1
) (
    input  logic [AW-1:0]       i_addr,
    input  logic [NWR-1:0]      i_wr_en,
    input  logic [NWR*AW-1:0]   i_wr_addr,
    input  logic [NWR*XLEN-1:0] i_wr_data,
    output logic                o_hit,
    output logic [XLEN-1:0]     o_data
);

    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        for (int j = 0; j < NWR; j++) begin
            if (i_wr_en[j] && (i_wr_addr[j*AW +: AW] == i_addr) && (i_addr != '0)) begin
                o_hit  = 1'b1;
                o_data = i_wr_data[j*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/riscv_regfile_mp.sv
// Multi-port integer register file with a per-register pending-write scoreboard.
// Define RISCV_REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module riscv_regfile_mp
    import riscv_regfile_mp_pkg::*;
#(
    parameter int XLEN = `XLEN,
    parameter int NREG = RV32I_NREG,
    parameter int AW   = $clog2(NREG),
    parameter int NRD  = 2,
    parameter int NWR  = 1
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic [NRD*AW-1:0]   i_rd_addr,
    output logic [NRD*XLEN-1:0] o_rd_data,
    output logic [NRD-1:0]      o_rd_busy,
    input  logic [NWR-1:0]      i_wr_en,
    input  logic [NWR*AW-1:0]   i_wr_addr,
    input  logic [NWR*XLEN-1:0] i_wr_data,
    input  logic                i_sb_set,
    input  logic [AW-1:0]       i_sb_addr,
    output logic [AW:0]         o_busy_cnt
);

    logic [XLEN-1:0] rf_q [NREG];
    logic [XLEN-1:0] wr_data [NREG];
    logic [NREG-1:0] wr_hit;
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] sb_set_vec;
    logic [AW:0]     cnt_q;
    logic [AW:0]     cnt_d;
    logic [AW:0]     n_clr;
    logic            n_set;

    for (genvar g = 0; g < NREG; g++) begin : g_wrsel
        riscv_regfile_wrsel #(
            .XLEN (XLEN),
            .AW   (AW),
            .NWR  (NWR)
        ) u_wrsel (
            .i_addr    (AW'(g)),
            .i_wr_en   (i_wr_en),
            .i_wr_addr (i_wr_addr),
            .i_wr_data (i_wr_data),
            .o_hit     (wr_hit[g]),
            .o_data    (wr_data[g])
        );
    end

    // Register 0 is reset like the others but never loaded, so it reads 0 forever.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (wr_hit[i]) begin
                    rf_q[i] <= wr_data[i];
                end
            end
        end
    end

    always_comb begin
        sb_set_vec = '0;
        if (i_sb_set && (i_sb_addr != '0)) begin
            sb_set_vec[i_sb_addr] = 1'b1;
        end
    end

    // A set wins over a clear of the same register: the newly issued producer is still in flight.
    assign busy_d = sb_set_vec | (busy_q & ~wr_hit);

    always_comb begin
        n_clr = '0;
        for (int i = 0; i < NREG; i++) begin
            n_clr = n_clr + (AW+1)'(busy_q[i] & wr_hit[i] & ~sb_set_vec[i]);
        end
        n_set = |(sb_set_vec & ~busy_q);
        cnt_d = cnt_q + (AW+1)'(n_set) - n_clr;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign o_busy_cnt = cnt_q;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   rd_addr;
        logic [XLEN-1:0] rd_data;
        logic            rd_busy;

        assign rd_addr = i_rd_addr[k*AW +: AW];

`ifdef RISCV_REGFILE_BYPASS_EN
        logic            byp_hit;
        logic [XLEN-1:0] byp_data;

        riscv_regfile_wrsel #(
            .XLEN (XLEN),
            .AW   (AW),
            .NWR  (NWR)
        ) u_byp (
            .i_addr    (rd_addr),
            .i_wr_en   (i_wr_en),
            .i_wr_addr (i_wr_addr),
            .i_wr_data (i_wr_data),
            .o_hit     (byp_hit),
            .o_data    (byp_data)
        );

        assign rd_data = byp_hit ? byp_data : rf_q[rd_addr];
        assign rd_busy = busy_q[rd_addr] & ~byp_hit;
`else
        assign rd_data = rf_q[rd_addr];
        assign rd_busy = busy_q[rd_addr];
`endif

        // Gated by reset so a forwarded write cannot leak out while reset is held.
        assign o_rd_data[k*XLEN +: XLEN] = i_rstn ? rd_data : '0;
        assign o_rd_busy[k]              = i_rstn & rd_busy;
    end

endmodule

// File: tb/tb_riscv_regfile_mp.sv
// Scoreboard bench for riscv_regfile_mp (NRD=2, NWR=2): directed cycles push expected read results,
// a monitor checks them at the falling edge of the same cycle.
module tb_riscv_regfile_mp;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int NRD  = 2;
    localparam int NWR  = 2;

    logic                i_clk = 1'b0;
    logic                i_rstn;
    logic [NRD*AW-1:0]   i_rd_addr;
    logic [NRD*XLEN-1:0] o_rd_data;
    logic [NRD-1:0]      o_rd_busy;
    logic [NWR-1:0]      i_wr_en;
    logic [NWR*AW-1:0]   i_wr_addr;
    logic [NWR*XLEN-1:0] i_wr_data;
    logic                i_sb_set;
    logic [AW-1:0]       i_sb_addr;
    logic [AW:0]         o_busy_cnt;

    riscv_regfile_mp #(
        .XLEN (XLEN),
        .NREG (NREG),
        .AW   (AW),
        .NRD  (NRD),
        .NWR  (NWR)
    ) dut (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_rd_addr  (i_rd_addr),
        .o_rd_data  (o_rd_data),
        .o_rd_busy  (o_rd_busy),
        .i_wr_en    (i_wr_en),
        .i_wr_addr  (i_wr_addr),
        .i_wr_data  (i_wr_data),
        .i_sb_set   (i_sb_set),
        .i_sb_addr  (i_sb_addr),
        .o_busy_cnt (o_busy_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        string       name;
        int          port;
        logic [31:0] data;
        logic        busy;
        logic [5:0]  cnt;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic expect_rd(input string n, input int p, input logic [31:0] d,
                             input logic b, input logic [5:0] c);
        exp_t e;
        e.name = n; e.port = p; e.data = d; e.busy = b; e.cnt = c;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge i_clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                total++;
                if (o_rd_data[e.port*XLEN +: XLEN] !== e.data) begin
                    bad++;
                    $display("FAIL %s data p%0d: got %h want %h", e.name, e.port,
                             o_rd_data[e.port*XLEN +: XLEN], e.data);
                end
                total++;
                if (o_rd_busy[e.port] !== e.busy) begin
                    bad++;
                    $display("FAIL %s busy p%0d: got %b want %b", e.name, e.port,
                             o_rd_busy[e.port], e.busy);
                end
                total++;
                if (o_busy_cnt !== e.cnt) begin
                    bad++;
                    $display("FAIL %s cnt: got %0d want %0d", e.name, o_busy_cnt, e.cnt);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge i_clk);
        #2;
        i_wr_en   = '0;
        i_wr_addr = '0;
        i_wr_data = '0;
        i_sb_set  = 1'b0;
        i_sb_addr = '0;
    endtask

    task automatic rd(input int p, input int a);
        i_rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic wr(input int p, input int a, input logic [31:0] d);
        i_wr_en[p]              = 1'b1;
        i_wr_addr[p*AW +: AW]   = AW'(a);
        i_wr_data[p*XLEN +: XLEN] = d;
    endtask

    task automatic sb(input int a);
        i_sb_set  = 1'b1;
        i_sb_addr = AW'(a);
    endtask

    initial begin
        i_rstn    = 1'b0;
        i_rd_addr = '0;
        i_wr_en   = '0;
        i_wr_addr = '0;
        i_wr_data = '0;
        i_sb_set  = 1'b0;
        i_sb_addr = '0;
        repeat (2) @(posedge i_clk);

        cyc(); rd(0, 5); rd(1, 0);
        expect_rd("reset_state", 0, 32'h0, 1'b0, 6'd0);

        cyc(); i_rstn = 1'b1; wr(0, 5, 32'hDEADBEEF); sb(5);
        expect_rd("x0_idle", 1, 32'h0, 1'b0, 6'd0);

        cyc(); rd(0, 5);
        expect_rd("x5_written", 0, 32'hDEADBEEF, 1'b1, 6'd1);

        cyc(); wr(0, 5, 32'h1); #1 i_rstn = 1'b0;
        expect_rd("reset_mid_write", 0, 32'h0, 1'b0, 6'd0);

        cyc(); i_rstn = 1'b1; rd(0, 5);
        expect_rd("x5_after_reset", 0, 32'h0, 1'b0, 6'd0);

        cyc(); wr(0, 0, 32'h12345678); sb(0); rd(0, 0);
        expect_rd("x0_write_same", 0, 32'h0, 1'b0, 6'd0);

        cyc(); rd(0, 0);
        expect_rd("x0_write_after", 0, 32'h0, 1'b0, 6'd0);

        cyc(); wr(0, 7, 32'h11); wr(1, 7, 32'h22); rd(0, 4); rd(1, 4);

        cyc(); rd(0, 7); rd(1, 7);
        expect_rd("x7_collision_p0", 0, 32'h22, 1'b0, 6'd0);
        expect_rd("x7_collision_p1", 1, 32'h22, 1'b0, 6'd0);

        cyc(); sb(3);

        cyc(); rd(0, 3);
        expect_rd("x3_set", 0, 32'h0, 1'b1, 6'd1);

        cyc(); wr(0, 3, 32'hA5); sb(3); rd(0, 4);
        expect_rd("x3_setclr_cycle", 0, 32'h0, 1'b0, 6'd1);

        cyc(); rd(0, 3);
        expect_rd("x3_setclr_after", 0, 32'hA5, 1'b1, 6'd1);

        cyc(); sb(1);

        cyc(); sb(2); rd(0, 1);
        expect_rd("x1_set", 0, 32'h0, 1'b1, 6'd2);

        cyc(); wr(0, 1, 32'h101); wr(1, 2, 32'h202); rd(0, 3); rd(1, 4);
        expect_rd("cnt_three", 0, 32'hA5, 1'b1, 6'd3);

        cyc(); rd(0, 1); rd(1, 2);
        expect_rd("dual_clear_x1", 0, 32'h101, 1'b0, 6'd1);
        expect_rd("dual_clear_x2", 1, 32'h202, 1'b0, 6'd1);

        cyc(); sb(9); rd(0, 3);
        expect_rd("x3_still_busy", 0, 32'hA5, 1'b1, 6'd1);

        cyc(); wr(0, 9, 32'hCAFE); rd(0, 9);
`ifdef RISCV_REGFILE_BYPASS_EN
        expect_rd("x9_bypass", 0, 32'hCAFE, 1'b0, 6'd2);
`else
        expect_rd("x9_no_bypass", 0, 32'h0, 1'b1, 6'd2);
`endif

        cyc(); rd(0, 9);
        expect_rd("x9_after", 0, 32'hCAFE, 1'b0, 6'd1);

        cyc(); wr(0, 8, 32'hAA); wr(1, 8, 32'hBB); rd(1, 8);
`ifdef RISCV_REGFILE_BYPASS_EN
        expect_rd("x8_bypass_prio", 1, 32'hBB, 1'b0, 6'd1);
`else
        expect_rd("x8_no_bypass", 1, 32'h0, 1'b0, 6'd1);
`endif

        cyc(); rd(0, 8); rd(1, 3);
        expect_rd("x8_after", 0, 32'hBB, 1'b0, 6'd1);
        expect_rd("x3_busy_end", 1, 32'hA5, 1'b1, 6'd1);

        cyc(); wr(1, 12, 32'h5);

        cyc(); rd(0, 12);
        expect_rd("clr_nonbusy", 0, 32'h5, 1'b0, 6'd1);

        repeat (2) @(posedge i_clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
